// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and execute-stage FSM states shared by alu_core and alu_exec_stage.
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOTA = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, signed overflow and carry/no-borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       func_i,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o,
  output logic             carry_o
);
  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [SHAMT_W-1:0]     sh;
  logic [2*WIDTH-1:0]     rol;
  logic [2*WIDTH-1:0]     ror;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
  assign sh   = b_i[SHAMT_W-1:0];
  // Rotates come from shifting a doubled copy of A, avoiding a WIDTH-sh shift.
  assign rol  = {a_i, a_i} << sh;
  assign ror  = {a_i, a_i} >> sh;
  always_comb begin
    res_o   = '0;
    ovf_o   = 1'b0;
    carry_o = 1'b0;
    case (func_i)
      OP_ADD: begin
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_o   = diff[WIDTH-1:0];
        carry_o = diff[WIDTH];
        ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_NOTA: res_o = ~a_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_SRA:  res_o = $signed(a_i) >>> sh;
      OP_SRL:  res_o = a_i >> sh;
      OP_SLL:  res_o = a_i << sh;
      OP_ROL:  res_o = rol[2*WIDTH-1:WIDTH];
      OP_ROR:  res_o = ror[WIDTH-1:0];
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered valid/ready execute stage; define ALU_MUL_EN for the iterative multiply (op 0111).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] RF_A,
  input  logic [WIDTH-1:0] RF_B,
  input  logic [WIDTH-1:0] Immed,
  input  logic             ALU_Bin_sel,
  input  logic [3:0]       ALU_func,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             ALU_Zero,
  output logic             ALU_Ovf,
  output logic             ALU_Carry,
  output logic             Busy
);
  logic [WIDTH-1:0] b_mux, core_res, mul_res;
  logic             core_ovf, core_carry;
  logic             accept, idle, start_mul, mul_done, load_alu;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;
  assign b_mux    = ALU_Bin_sel ? Immed : RF_B;
  assign In_ready = idle & (!out_valid_q | Out_ready);
  assign accept   = In_valid & In_ready;
  assign load_alu = accept & !start_mul;
  alu_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
    .a_i     (RF_A),
    .b_i     (b_mux),
    .func_i  (ALU_func),
    .res_o   (core_res),
    .ovf_o   (core_ovf),
    .carry_o (core_carry)
  );
`ifdef ALU_MUL_EN
  state_e             state_q, state_d;
  logic               busy;
  logic               mul_last;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  assign start_mul = accept & (ALU_func == OP_MUL);
  assign mul_last  = (state_q == ST_MUL) & (cnt_q == SHAMT_W'(WIDTH-1));
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (start_mul ? ST_MUL : ST_IDLE)
                                   : (mul_last ? ST_IDLE : ST_MUL);
  end
  always_comb begin
    idle = (state_q == ST_IDLE);
    busy = (state_q == ST_MUL);
  end
  // One shift-add step per cycle: multiplicand walks left, multiplier walks right.
  always_comb begin
    mcand_d  = start_mul ? RF_A  : busy ? mcand_q << 1  : mcand_q;
    mplier_d = start_mul ? b_mux : busy ? mplier_q >> 1 : mplier_q;
    acc_d    = start_mul ? '0    : busy ? acc_q + (mplier_q[0] ? mcand_q : '0) : acc_q;
    cnt_d    = start_mul ? '0    : busy ? cnt_q + SHAMT_W'(1) : cnt_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mul_done = mul_last;
  assign mul_res  = acc_d;
  assign Busy     = busy;
`else
  assign idle      = 1'b1;
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign Busy      = 1'b0;
`endif
  // MUL is only entered with the register free, so mul_done and load_alu never coincide.
  always_comb begin
    out_valid_d = mul_done | load_alu | (out_valid_q & !Out_ready);
    alu_out_d   = mul_done ? mul_res : load_alu ? core_res : alu_out_q;
    zero_d      = mul_done ? (mul_res == '0) : load_alu ? (core_res == '0) : zero_q;
    ovf_d       = mul_done ? 1'b0 : load_alu ? core_ovf : ovf_q;
    carry_d     = mul_done ? 1'b0 : load_alu ? core_carry : carry_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
    end
  end
  assign Out_valid = out_valid_q;
  assign ALU_out   = alu_out_q;
  assign ALU_Zero  = zero_q;
  assign ALU_Ovf   = ovf_q;
  assign ALU_Carry = carry_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random stimulus against a one-entry scoreboard model of the execute stage.
module tb_alu_exec_stage;
  logic        Clk, Reset_n, In_valid, In_ready, ALU_Bin_sel, Out_valid, Out_ready;
  logic [31:0] RF_A, RF_B, Immed, ALU_out;
  logic [3:0]  ALU_func;
  logic        ALU_Zero, ALU_Ovf, ALU_Carry, Busy;
  typedef struct {logic [31:0] r; logic z; logic o; logic c;} exp_t;
  exp_t exp_q[$];
  exp_t mul_exp;
  int   mul_left = 0;
  int   n_vec = 0;
  int   n_err = 0;
  alu_exec_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .ALU_out(ALU_out), .ALU_Zero(ALU_Zero), .ALU_Ovf(ALU_Ovf),
    .ALU_Carry(ALU_Carry), .Busy(Busy)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint maxs = 64'sd2147483647;
    longint mins = -64'sd2147483648;
    longint s;
    int     sh = int'(b[4:0]);
    e.r = 0; e.o = 0; e.c = 0;
    case (f)
      4'd0: begin
        s = sa + sb; e.r = a + b;
        e.c = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
        e.o = (s > maxs) || (s < mins);
      end
      4'd1: begin
        s = sa - sb; e.r = a - b;
        e.c = (a >= b);
        e.o = (s > maxs) || (s < mins);
      end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = ~a;
      4'd5: e.r = ~(a & b);
      4'd6: e.r = ~(a | b);
      4'd8: e.r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd9: e.r = a >> sh;
      4'd10: e.r = a << sh;
      4'd12: e.r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd13: e.r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
      default: e.r = 0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction
  task automatic check_outputs();
    chk("out_valid", 32'(Out_valid), 32'(exp_q.size() != 0));
    chk("busy", 32'(Busy), 32'(mul_left > 0));
    if (exp_q.size() != 0) begin
      chk("alu_out", ALU_out, exp_q[0].r);
      chk("flags_zoc", {29'h0, ALU_Zero, ALU_Ovf, ALU_Carry}, {29'h0, exp_q[0].z, exp_q[0].o, exp_q[0].c});
    end
  endtask
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] rb, input logic [31:0] imm,
                      input logic sel, input logic [3:0] f, input logic ordy);
    logic [31:0] b;
    logic        m_rdy, acc, pop;
    check_outputs();
    In_valid = v; RF_A = a; RF_B = rb; Immed = imm; ALU_Bin_sel = sel; ALU_func = f; Out_ready = ordy;
    #1;
    m_rdy = (mul_left == 0) && ((exp_q.size() == 0) || ordy);
    chk("in_ready", 32'(In_ready), 32'(m_rdy));
    b   = sel ? imm : rb;
    pop = (exp_q.size() != 0) && ordy;
    acc = v && m_rdy;
    if (pop) void'(exp_q.pop_front());
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) exp_q.push_back(mul_exp);
    end
`ifdef ALU_MUL_EN
    if (acc && f == 4'd7) begin
      mul_left = 32;
      mul_exp.r = a * b; mul_exp.z = (mul_exp.r == 0); mul_exp.o = 0; mul_exp.c = 0;
      acc = 1'b0;
    end
`endif
    if (acc) exp_q.push_back(ref_alu(a, b, f));
    @(negedge Clk);
  endtask
  initial begin
    Reset_n = 1'b0; In_valid = 1'b1; Out_ready = 1'b0;
    RF_A = 0; RF_B = 0; Immed = 0; ALU_Bin_sel = 0; ALU_func = 0;
    #3;
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_alu_out", ALU_out, 32'd0);
    chk("rst_flags", {28'h0, ALU_Zero, ALU_Ovf, ALU_Carry, Busy}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_hold_valid", 32'(Out_valid), 32'd0);
    Reset_n = 1'b1;
    In_valid = 1'b0;
    @(negedge Clk);
    step(1, 32'h7FFF_FFFF, 32'd1, 32'd0, 0, 4'd0, 0);
    chk("add_ovf_out", ALU_out, 32'h8000_0000);
    chk("add_ovf_flags", {29'h0, ALU_Zero, ALU_Ovf, ALU_Carry}, 32'b010);
    step(1, 32'd5, 32'd99, 32'd5, 1, 4'd1, 1);
    chk("sub_imm_out", ALU_out, 32'd0);
    chk("sub_imm_flags", {29'h0, ALU_Zero, ALU_Ovf, ALU_Carry}, 32'b101);
    step(1, 32'h8000_0001, 32'd4, 32'd0, 0, 4'd8, 1);
    chk("sra_out", ALU_out, 32'hF800_0000);
    step(1, 32'h8000_0001, 32'd0, 32'd4, 1, 4'd13, 1);
    chk("ror_out", ALU_out, 32'h1800_0000);
    step(1, 32'h1234_5678, 32'd0, 32'd0, 0, 4'd14, 1);
    step(1, 32'hFFFF_FFFF, 32'h1, 32'd0, 0, 4'd7, 1);
    step(1, 32'h8000_0000, 32'h8000_0000, 32'd0, 0, 4'd0, 1);
    step(1, 32'h8000_0000, 32'h1, 32'd0, 0, 4'd1, 1);
    step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
    step(1, 32'd10, 32'd3, 32'd0, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'd20 + i, 32'd7, 32'd0, 0, 4'd1, 0);
    for (int i = 0; i < 4; i++) step(1, 32'd40 + i, 32'hF0, 32'd0, 0, 4'd3, 1);
    step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom), ($urandom % 3) != 0);
    step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
    step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
`ifdef ALU_MUL_EN
    step(1, 32'd1234, 32'd5678, 32'd0, 0, 4'd7, 1);
    for (int i = 0; i < 32; i++) step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 0);
    chk("mul_out", ALU_out, 32'd7006652);
    step(1, 32'd1234, 32'd0, 32'd5678, 1, 4'd7, 1);
    for (int i = 0; i < 10; i++) step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
    Reset_n = 1'b0;
    exp_q.delete();
    mul_left = 0;
    #2;
    chk("mul_abort_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 40; i++) step(0, 32'd0, 32'd0, 32'd0, 0, 4'd0, 1);
`endif
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
